// File: rtl/din_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : din_debounce_sync
// Brief    : Synchronizes an asynchronous bouncy input and accepts a new level
//            only after STABLE_CYCLES consecutive identical samples.
// Revision : 1.0 - initial release
// ============================================================================
module din_debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din_raw,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int                 c_CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_STABLE = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE_LOW   = 2'd0;
    localparam logic [1:0] c_CHECK_HIGH = 2'd1;
    localparam logic [1:0] c_IDLE_HIGH  = 2'd2;
    localparam logic [1:0] c_CHECK_LOW  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_dout;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;

    logic                   w_s;
    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic [1:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_dout_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   w_busy_nxt;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + c_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_state <= c_IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], din_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // A sample matching the current level in a CHECK state aborts the check.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_dout_nxt  = r_dout;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            c_IDLE_LOW: begin
                if (w_s) begin
                    w_state_nxt = c_CHECK_HIGH;
                    w_cnt_nxt   = c_ONE;
                end
            end
            c_CHECK_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = c_IDLE_LOW;
                end else if (w_cnt_inc == c_STABLE) begin
                    w_state_nxt = c_IDLE_HIGH;
                    w_dout_nxt  = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            c_IDLE_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = c_CHECK_LOW;
                    w_cnt_nxt   = c_ONE;
                end
            end
            c_CHECK_LOW: begin
                if (w_s) begin
                    w_state_nxt = c_IDLE_HIGH;
                end else if (w_cnt_inc == c_STABLE) begin
                    w_state_nxt = c_IDLE_LOW;
                    w_dout_nxt  = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = c_IDLE_LOW;
            end
        endcase
        w_busy_nxt = (w_state_nxt == c_CHECK_HIGH) || (w_state_nxt == c_CHECK_LOW);
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_din_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_din_debounce_sync
// Brief    : Scoreboard bench for din_debounce_sync against a sliding-window
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_din_debounce_sync;

    localparam int c_SYNC   = 2;
    localparam int c_STABLE = 4;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic din_raw = 1'b0;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: delay line for the synchronizer, window of seen samples.
    logic       din_hist[$];
    logic       seen[$];
    logic       m_dout;
    logic [3:0] exp_q[$];

    din_debounce_sync #(
        .SYNC_STAGES  (c_SYNC),
        .STABLE_CYCLES(c_STABLE)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .din_raw(din_raw),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_bits(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: {dout,rise,fall,busy} got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        din_hist.delete();
        seen.delete();
        for (int i = 0; i < c_SYNC; i++) din_hist.push_back(1'b0);
        m_dout = 1'b0;
    endtask

    // A level is accepted when the last c_STABLE seen samples all differ from it.
    task automatic model_step(input logic d);
        logic sv;
        logic m_rise;
        logic m_fall;
        bit   all_diff;
        din_hist.push_back(d);
        sv = din_hist.pop_front();
        seen.push_back(sv);
        if (seen.size() > c_STABLE) void'(seen.pop_front());
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (seen.size() == c_STABLE) begin
            all_diff = 1'b1;
            foreach (seen[i]) if (seen[i] == m_dout) all_diff = 1'b0;
            if (all_diff) begin
                m_dout = ~m_dout;
                if (m_dout) m_rise = 1'b1;
                else        m_fall = 1'b1;
            end
        end
        exp_q.push_back({m_dout, m_rise, m_fall, (sv != m_dout)});
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (reset) begin
                model_clear();
                exp_q.push_back(4'b0000);
            end else begin
                model_step(din_raw);
            end
        end
    end

    initial forever begin
        @(posedge reset);
        model_clear();
    end

    // Monitor: every cycle the DUT presents a level; compare against the queue.
    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty @%0t: got no expected entry, required one", $time);
        end else begin
            chk_bits("scoreboard", {dout, rise, fall, busy}, exp_q.pop_front());
        end
    end

    task automatic drive(input logic v, input int n);
        @(negedge clk);
        din_raw = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic measure_latency(input string name, input logic target);
        int lat;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (dout == target && lat == 0) lat = i;
        end
        chk_int(name, lat, c_SYNC + c_STABLE);
    endtask

    initial begin
        int waited;
        bit level;
        // 1: reset then idle low
        #13 reset = 1'b0;
        chk_bits("after_reset", {dout, rise, fall, busy}, 4'b0000);
        drive(1'b0, 10);

        // 2: rising level, latency
        @(negedge clk);
        din_raw = 1'b1;
        measure_latency("rise_latency", 1'b1);

        // 4: falling level, latency
        @(negedge clk);
        din_raw = 1'b0;
        measure_latency("fall_latency", 1'b0);

        // 3: glitch of exactly 3 clocks
        drive(1'b1, 3);
        drive(1'b0, 10);
        chk_bits("glitch_no_rise", {dout, rise, fall}, 4'b0000);

        // 5: async reset mid CHECK_HIGH
        @(negedge clk);
        din_raw = 1'b1;
        waited = 0;
        while (busy !== 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk_int("busy_seen", int'(busy === 1'b1), 1);
        #2 reset = 1'b1;
        #1;
        chk_bits("async_reset_immediate", {dout, rise, fall, busy}, 4'b0000);
        reset = 1'b0;
        measure_latency("post_reset_rise_latency", 1'b1);

        // 6: toggle every clock
        level = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(level, 1);
            level = ~level;
        end
        drive(1'b1, 8);
        chk_bits("toggle_hold", {1'b0, dout, 2'b00}, 4'b0100);

        // Randomized bouncing levels
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        drive(1'b0, 10);

        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
